// File: rtl/config_chain_loader.sv
// ============================================================================
// config_chain_loader
// ----------------------------------------------------------------------------
// Transmitting end of the ConfigIn/ConfigOut serial configuration chain of a
// CGRA tile column. Bitstream words arrive over a valid/ready interface, most
// significant word first, and are serialised MSB-first onto the chain head.
// shift_en marks every cycle in which the chain must advance; it is used
// outside this block to gate Config_Clock to the chain.
//
// Word 0 carries only the leftover bits of the chain (its low FIRST_N bits);
// every later word carries a full WORD_W bits. After CHAIN_LEN shifts, the
// first bit sent sits at the chain tail and the last bit sent at the head.
//
// Parameters:
//   CHAIN_LEN   total bits in the target chain (>= 1)
//   WORD_W      width of one bitstream word (>= 2)
//
// Ports:
//   Config_Clock  in   block clock
//   Config_Reset  in   asynchronous, active-high reset
//   start         in   one-cycle request to begin a full chain load
//   word_valid    in   word_data holds a valid word
//   word_data     in   bitstream word, most-significant word first
//   word_ready    out  loader accepts a word this cycle
//   ConfigOut     out  serial bit to the chain head's ConfigIn
//   shift_en      out  chain advances one bit this cycle
//   busy          out  a load is in progress
//   done          out  one-cycle pulse when the load completes
//
// Optional readback (define CONFIG_READBACK_EN):
//   chain_tail    in   ConfigOut of the final chain cell
//   rb_valid      out  one-cycle pulse after each word's last shift
//   rb_data       out  bits that fell off the chain tail while that word was
//                      shifted in, right-aligned, upper bits zero
// ============================================================================

module config_chain_loader #(
    parameter int CHAIN_LEN = 46,
    parameter int WORD_W    = 32
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ConfigOut,
    output logic              shift_en,
    output logic              busy,
    output logic              done
`ifdef CONFIG_READBACK_EN
    ,
    input  logic              chain_tail,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int NWORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    // Bits carried by word 0; the remaining words are all full.
    localparam int FIRST_N  = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    // Left shift that moves word 0's valid field up to the MSB.
    localparam int FIRST_SKIP = WORD_W - FIRST_N;

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int IDX_W = $clog2(NWORDS + 1);

    localparam logic [CNT_W-1:0] FIRST_N_C = CNT_W'(FIRST_N);
    localparam logic [CNT_W-1:0] FULL_N_C  = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NWORDS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e            state_q;
    logic [IDX_W-1:0]  word_idx_q;   // words accepted so far in this load
    logic [CNT_W-1:0]  bit_cnt_q;    // bits still to send, including current
    logic [WORD_W-1:0] shreg_q;      // bits after the one on ConfigOut, MSB next
    logic              word_ready_q;
    logic              config_out_q;
    logic              shift_en_q;
    logic              busy_q;
    logic              done_q;

`ifdef CONFIG_READBACK_EN
    logic [WORD_W-1:0] rb_acc_q;     // tail bits captured for the current word
    logic              rb_valid_q;
    logic [WORD_W-1:0] rb_data_q;
`endif

    // ------------------------------------------------------------------------
    // Word load preparation
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]  load_n_d;
    logic [WORD_W-1:0] load_word_d;

    // NOTE: every signal written here gets a value on every path first, so
    // no latch can be inferred.
    always_comb begin
        load_n_d    = FULL_N_C;
        load_word_d = word_data;
        if (word_idx_q == '0) begin
            load_n_d    = FIRST_N_C;
            // Unused upper bits of word 0 fall off the top here.
            load_word_d = word_data << FIRST_SKIP;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Config_Clock or posedge Config_Reset) begin
        if (Config_Reset) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            word_ready_q <= 1'b0;
            config_out_q <= 1'b0;
            shift_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CONFIG_READBACK_EN
            rb_acc_q     <= '0;
            rb_valid_q   <= 1'b0;
            rb_data_q    <= '0;
`endif
        end else begin
            // Pulse outputs default low.
            done_q <= 1'b0;
`ifdef CONFIG_READBACK_EN
            rb_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= WAIT_WORD;
                        word_idx_q   <= '0;
                        word_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end

                WAIT_WORD: begin
                    // word_ready is high for the whole of this state.
                    if (word_valid) begin
                        state_q      <= SHIFT;
                        word_ready_q <= 1'b0;
                        shift_en_q   <= 1'b1;
                        config_out_q <= load_word_d[WORD_W-1];
                        shreg_q      <= load_word_d << 1;
                        bit_cnt_q    <= load_n_d;
                        word_idx_q   <= word_idx_q + IDX_ONE;
`ifdef CONFIG_READBACK_EN
                        rb_acc_q     <= '0;
`endif
                    end
                end

                SHIFT: begin
`ifdef CONFIG_READBACK_EN
                    // The bit leaving the tail at this edge is the old
                    // configuration; collect it for readback.
                    rb_acc_q <= (rb_acc_q << 1) | WORD_W'(chain_tail);
`endif
                    if (bit_cnt_q == CNT_ONE) begin
                        shift_en_q   <= 1'b0;
                        config_out_q <= 1'b0;
`ifdef CONFIG_READBACK_EN
                        rb_valid_q   <= 1'b1;
                        rb_data_q    <= (rb_acc_q << 1) | WORD_W'(chain_tail);
`endif
                        if (word_idx_q == IDX_LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= WAIT_WORD;
                            word_ready_q <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q    <= bit_cnt_q - CNT_ONE;
                        config_out_q <= shreg_q[WORD_W-1];
                        shreg_q      <= shreg_q << 1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q      <= IDLE;
                    word_ready_q <= 1'b0;
                    shift_en_q   <= 1'b0;
                    config_out_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign word_ready = word_ready_q;
    assign ConfigOut  = config_out_q;
    assign shift_en   = shift_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef CONFIG_READBACK_EN
    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;
`endif

endmodule
